bisr_repair_table: RTL and testbench
====================================

# bisr_repair_table

Fault-address table between the BIST engine and the BISR remap logic of the 64-bank (64 × 1K × 8) main memory. It captures each failing {bank, word} address reported by BIST, deduplicates it, and assigns the next free spare-memory location. During normal operation it answers a registered lookup for every user address: hit/miss plus the spare bank and word that replace the faulty location.

## Interface
Parameters:
- ENTRIES, 16: table depth, 1..3200 (25 spare banks × 128 words).
- IDX_W, $clog2(ENTRIES+1): width of COUNT.

Ports:
- CLK  in  1  clock; every register updates on the rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- CLR  in  1  synchronous table clear; pulsed at the start of each BIST run.
- FAIL_VALID  in  1  BIST reports a failing location this cycle.
- FAIL_SELECT  in  6  failing main bank.
- FAIL_ADDR  in  10  failing word within the bank.
- LOOKUP_EN  in  1  user access valid.
- LOOKUP_ADDR  in  16  user address: [15:10] bank, [9:0] word.
- HIT  out  1  registered; the lookup address is in the table.
- SPARE_SEL  out  5  registered; spare bank for the hit entry.
- SPARE_ADDR  out  7  registered; spare word for the hit entry.
- COUNT  out  IDX_W  number of valid entries.
- FULL  out  1  COUNT == ENTRIES.
- OVERFLOW  out  1  sticky; a new fault was dropped because the table was full.

## Operation
- Storage: ENTRIES slots, each holding valid + 16-bit tag {bank, word}. Slot i maps permanently to spare location SPARE_SEL = i / 128, SPARE_ADDR = i % 128.
- Insert, on FAIL_VALID with CLR low:
  - The tag {FAIL_SELECT, FAIL_ADDR} is compared against all valid slots.
  - Match: duplicate; no change.
  - No match and not FULL: write slot[COUNT] with valid = 1, then COUNT += 1.
  - No match and FULL: OVERFLOW <= 1; table unchanged.
- Slots fill strictly in order 0, 1, 2, …; there is no deletion. Valid entries are always a contiguous prefix.
- Lookup, on LOOKUP_EN:
  - Compare LOOKUP_ADDR against all valid slots in parallel.
  - The lowest matching index drives SPARE_SEL/SPARE_ADDR. Only one match can exist, because inserts are deduplicated.
  - No match or LOOKUP_EN low: HIT = 0, SPARE_SEL = 0, SPARE_ADDR = 0.
- CLR: clears all valid bits, COUNT and OVERFLOW. It takes priority over a simultaneous FAIL_VALID, which is dropped.

## Timing
- Reset values: HIT 0, SPARE_SEL 0, SPARE_ADDR 0, COUNT 0, FULL 0, OVERFLOW 0, all valid bits 0.
- Lookup latency is 1 cycle: HIT/SPARE_* on edge N+1 reflect LOOKUP_ADDR sampled at edge N.
- Insert and lookup of the same address in the same cycle: the lookup sees the pre-insert table (miss). A lookup one cycle later hits.
- CLR with LOOKUP_EN in the same cycle: the lookup uses the pre-clear table. Results from the next cycle onward miss.
- Back-to-back FAIL_VALID is accepted at one insert per cycle with no stall.
- COUNT, FULL and OVERFLOW are registered and update at the edge that commits the insert.
- RSTN assertion mid-operation clears everything immediately and asynchronously. The first insert after deassertion goes to slot 0.

## Structure
- Shared package holds:
  - BANK_W = 6, WORD_W = 10, TAG_W = 16.
  - SPARE_BANKS = 25, SPARE_WORD_W = 7, SPARE_SEL_W = 5.
  - The slot-to-spare mapping function.
- One sub-module, repair_match_enc: parallel tag compare against the valid vector, producing a match flag and the lowest matching index. It is instantiated twice: once for insert dedup, once for lookup.

## Test plan
- Reset, then FAIL_VALID with {bank 3, word 0x05} -> COUNT = 1. Next cycle, lookup 0x0C05 -> HIT = 1, SPARE_SEL = 0, SPARE_ADDR = 0 one cycle later.
- Insert the same fault three times -> COUNT stays 1, OVERFLOW stays 0.
- With ENTRIES = 16, insert 17 distinct faults -> FULL = 1 after the 16th, OVERFLOW = 1 after the 17th. Slot 15 lookup returns SPARE_ADDR = 15.
- With ENTRIES = 200, insert 129 faults -> the 129th fault looks up as SPARE_SEL = 1, SPARE_ADDR = 0.
- FAIL_VALID and lookup of the same new address in one cycle -> HIT = 0. Repeat the lookup the next cycle -> HIT = 1.
- CLR together with FAIL_VALID after 4 entries -> COUNT = 0 and OVERFLOW = 0, the new fault is not stored, and later lookups miss. Also assert RSTN mid-insert burst -> all outputs return to 0.

Source files
------------

// File: rtl/bisr_repair_table_pkg.sv
// Shared widths and slot-to-spare mapping for the BISR fault-address table.
package bisr_repair_table_pkg;

   localparam int unsigned BANK_W       = 6;
   localparam int unsigned WORD_W       = 10;
   localparam int unsigned TAG_W        = 16;
   localparam int unsigned SPARE_BANKS  = 25;
   localparam int unsigned SPARE_WORD_W = 7;
   localparam int unsigned SPARE_SEL_W  = 5;
   localparam int unsigned SLOT_W       = SPARE_SEL_W + SPARE_WORD_W;
   localparam int unsigned MAX_ENTRIES  = SPARE_BANKS * (2 ** SPARE_WORD_W);

   typedef struct packed {
      logic [SPARE_SEL_W-1:0]  sel;
      logic [SPARE_WORD_W-1:0] addr;
   } spare_loc_t;

   // Slot i lives at spare bank i / 128, word i % 128.
   function automatic spare_loc_t slot_to_spare(input logic [SLOT_W-1:0] slot);
      spare_loc_t loc;
      loc.sel  = slot[SLOT_W-1:SPARE_WORD_W];
      loc.addr = slot[SPARE_WORD_W-1:0];
      return loc;
   endfunction

endpackage

// File: rtl/repair_match_enc.sv
// Parallel tag compare across valid slots; reports a hit and the lowest matching index.
module repair_match_enc
   import bisr_repair_table_pkg::*;
#(
   parameter int unsigned N     = 16,
   parameter int unsigned IDX_W = 5
) (
   input  logic [TAG_W-1:0] tags [N],
   input  logic [N-1:0]     valid,
   input  logic [TAG_W-1:0] key,
   output logic             match,
   output logic [IDX_W-1:0] idx
);

   // Scan high to low so the lowest matching slot wins.
   always_comb begin
      match = 1'b0;
      idx   = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (valid[i] && (tags[i] == key)) begin
            match = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/bisr_repair_table.sv
// Deduplicating BIST fault-address table with registered lookup into spare locations.
module bisr_repair_table
   import bisr_repair_table_pkg::*;
#(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned IDX_W   = $clog2(ENTRIES + 1)
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic                    CLR,
   input  logic                    FAIL_VALID,
   input  logic [BANK_W-1:0]       FAIL_SELECT,
   input  logic [WORD_W-1:0]       FAIL_ADDR,
   input  logic                    LOOKUP_EN,
   input  logic [TAG_W-1:0]        LOOKUP_ADDR,
   output logic                    HIT,
   output logic [SPARE_SEL_W-1:0]  SPARE_SEL,
   output logic [SPARE_WORD_W-1:0] SPARE_ADDR,
   output logic [IDX_W-1:0]        COUNT,
   output logic                    FULL,
   output logic                    OVERFLOW
);

   logic [TAG_W-1:0]        tag_q [ENTRIES];
   logic [ENTRIES-1:0]      valid_q, valid_d;
   logic [IDX_W-1:0]        count_q, count_d;
   logic                    ovf_q, ovf_d;
   logic                    hit_q, hit_d;
   logic [SPARE_SEL_W-1:0]  sel_q, sel_d;
   logic [SPARE_WORD_W-1:0] addr_q, addr_d;

   logic [TAG_W-1:0] ins_key;
   logic             ins_match, lk_match, full, wr_en;
   logic [IDX_W-1:0] ins_idx, lk_idx;
   spare_loc_t       lk_loc;

   assign ins_key = {FAIL_SELECT, FAIL_ADDR};
   assign full    = (count_q == IDX_W'(ENTRIES));

   repair_match_enc #(
      .N     (ENTRIES),
      .IDX_W (IDX_W)
   ) u_ins_enc (
      .tags  (tag_q),
      .valid (valid_q),
      .key   (ins_key),
      .match (ins_match),
      .idx   (ins_idx)
   );

   repair_match_enc #(
      .N     (ENTRIES),
      .IDX_W (IDX_W)
   ) u_lk_enc (
      .tags  (tag_q),
      .valid (valid_q),
      .key   (LOOKUP_ADDR),
      .match (lk_match),
      .idx   (lk_idx)
   );

   always_comb begin
      valid_d = valid_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      if (CLR) begin
         valid_d = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (FAIL_VALID && !ins_match) begin
         if (!full) begin
            wr_en   = 1'b1;
            count_d = count_q + IDX_W'(1);
            for (int i = 0; i < int'(ENTRIES); i++) begin
               if (count_q == IDX_W'(i)) valid_d[i] = 1'b1;
            end
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   // Lookup sees the pre-insert / pre-clear table.
   always_comb begin
      lk_loc = slot_to_spare(SLOT_W'(lk_idx));
      hit_d  = LOOKUP_EN && lk_match;
      sel_d  = hit_d ? lk_loc.sel : '0;
      addr_d = hit_d ? lk_loc.addr : '0;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         valid_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         hit_q   <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         hit_q   <= hit_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
      end
   end

   // Tags are qualified by valid bits, so they need no reset.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
         if (wr_en && (count_q == IDX_W'(i))) tag_q[i] <= ins_key;
      end
   end

   assign HIT        = hit_q;
   assign SPARE_SEL  = sel_q;
   assign SPARE_ADDR = addr_q;
   assign COUNT      = count_q;
   assign FULL       = full;
   assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_bisr_repair_table.sv
// Self-checking bench: two table depths driven in lockstep against a list-based reference model.
module tb_bisr_repair_table;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic        CLR, FAIL_VALID, LOOKUP_EN;
   logic [5:0]  FAIL_SELECT;
   logic [9:0]  FAIL_ADDR;
   logic [15:0] LOOKUP_ADDR;

   logic       hit_a, full_a, ovf_a, hit_b, full_b, ovf_b;
   logic [4:0] sel_a, sel_b, cnt_a;
   logic [6:0] addr_a, addr_b;
   logic [7:0] cnt_b;

   always #5 CLK = ~CLK;

   bisr_repair_table #(.ENTRIES(16)) dut_a (
      .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .FAIL_VALID(FAIL_VALID), .FAIL_SELECT(FAIL_SELECT),
      .FAIL_ADDR(FAIL_ADDR), .LOOKUP_EN(LOOKUP_EN), .LOOKUP_ADDR(LOOKUP_ADDR), .HIT(hit_a),
      .SPARE_SEL(sel_a), .SPARE_ADDR(addr_a), .COUNT(cnt_a), .FULL(full_a), .OVERFLOW(ovf_a)
   );

   bisr_repair_table #(.ENTRIES(200)) dut_b (
      .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .FAIL_VALID(FAIL_VALID), .FAIL_SELECT(FAIL_SELECT),
      .FAIL_ADDR(FAIL_ADDR), .LOOKUP_EN(LOOKUP_EN), .LOOKUP_ADDR(LOOKUP_ADDR), .HIT(hit_b),
      .SPARE_SEL(sel_b), .SPARE_ADDR(addr_b), .COUNT(cnt_b), .FULL(full_b), .OVERFLOW(ovf_b)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: ordered list of stored fault addresses per table.
   logic [15:0] mtab [2][200];
   int          mcnt [2];
   bit          movf [2];
   int          cap  [2];
   bit          e_hit [2];
   int          e_slot [2];

   typedef struct {
      bit          clr;
      bit          fv;
      logic [15:0] ftag;
      bit          len;
      logic [15:0] laddr;
      bit          x_hit;
      int          x_sel;
      int          x_addr;
      int          x_cnt;
      bit          x_full;
      bit          x_ovf;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("hit16",   int'(hit_a),  int'(e_hit[0]));
      check("sel16",   int'(sel_a),  e_hit[0] ? e_slot[0] / 128 : 0);
      check("addr16",  int'(addr_a), e_hit[0] ? e_slot[0] % 128 : 0);
      check("count16", int'(cnt_a),  mcnt[0]);
      check("full16",  int'(full_a), int'(mcnt[0] == cap[0]));
      check("ovf16",   int'(ovf_a),  int'(movf[0]));
      check("hit200",  int'(hit_b),  int'(e_hit[1]));
      check("sel200",  int'(sel_b),  e_hit[1] ? e_slot[1] / 128 : 0);
      check("addr200", int'(addr_b), e_hit[1] ? e_slot[1] % 128 : 0);
      check("count200", int'(cnt_b), mcnt[1]);
      check("full200", int'(full_b), int'(mcnt[1] == cap[1]));
      check("ovf200",  int'(ovf_b),  int'(movf[1]));
   endtask

   function automatic bit model_has(input int d, input logic [15:0] t);
      for (int j = 0; j < mcnt[d]; j++) if (mtab[d][j] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic step(input bit clr, input bit fv, input logic [15:0] ftag, input bit len,
                       input logic [15:0] laddr);
      for (int d = 0; d < 2; d++) begin
         e_hit[d]  = 1'b0;
         e_slot[d] = 0;
         if (len) begin
            for (int j = mcnt[d] - 1; j >= 0; j--) begin
               if (mtab[d][j] == laddr) begin
                  e_hit[d]  = 1'b1;
                  e_slot[d] = j;
               end
            end
         end
         if (clr) begin
            mcnt[d] = 0;
            movf[d] = 1'b0;
         end else if (fv && !model_has(d, ftag)) begin
            if (mcnt[d] < cap[d]) begin
               mtab[d][mcnt[d]] = ftag;
               mcnt[d]++;
            end else begin
               movf[d] = 1'b1;
            end
         end
      end
      CLR         = clr;
      FAIL_VALID  = fv;
      FAIL_SELECT = ftag[15:10];
      FAIL_ADDR   = ftag[9:0];
      LOOKUP_EN   = len;
      LOOKUP_ADDR = laddr;
      @(posedge CLK);
      #1;
      check_model();
   endtask

   task automatic idle_inputs();
      CLR = 1'b0; FAIL_VALID = 1'b0; FAIL_SELECT = '0; FAIL_ADDR = '0;
      LOOKUP_EN = 1'b0; LOOKUP_ADDR = '0;
   endtask

   // Asynchronous reset asserted away from any clock edge; inputs left as they are.
   task automatic async_reset();
      #1;
      RSTN = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         mcnt[d] = 0; movf[d] = 1'b0; e_hit[d] = 1'b0; e_slot[d] = 0;
      end
      check_model();
      idle_inputs();
      #1;
      RSTN = 1'b1;
   endtask

   logic [15:0] tag;
   logic [15:0] fill_tag [129];

   initial begin
      cap[0] = 16;
      cap[1] = 200;
      vecs[0] = '{0, 1, 16'h0C05, 0, 16'h0000, 0, 0, 0, 1, 0, 0};
      vecs[1] = '{0, 0, 16'h0000, 1, 16'h0C05, 1, 0, 0, 1, 0, 0};
      vecs[2] = '{0, 1, 16'h0C05, 0, 16'h0000, 0, 0, 0, 1, 0, 0};
      vecs[3] = '{0, 1, 16'h0C05, 1, 16'h0C06, 0, 0, 0, 1, 0, 0};
      vecs[4] = '{0, 1, 16'h17FF, 1, 16'h17FF, 0, 0, 0, 2, 0, 0};
      vecs[5] = '{0, 0, 16'h0000, 1, 16'h17FF, 1, 0, 1, 2, 0, 0};

      idle_inputs();
      RSTN = 1'b0;
      for (int d = 0; d < 2; d++) begin
         mcnt[d] = 0; movf[d] = 1'b0; e_hit[d] = 1'b0; e_slot[d] = 0;
      end
      repeat (2) @(posedge CLK);
      #1;
      check_model();
      RSTN = 1'b1;

      // Directed table: first insert, lookup, duplicates, insert/lookup collision.
      for (int v = 0; v < 6; v++) begin
         step(vecs[v].clr, vecs[v].fv, vecs[v].ftag, vecs[v].len, vecs[v].laddr);
         check($sformatf("vec%0d_hit", v),   int'(hit_a),  int'(vecs[v].x_hit));
         check($sformatf("vec%0d_sel", v),   int'(sel_a),  vecs[v].x_sel);
         check($sformatf("vec%0d_addr", v),  int'(addr_a), vecs[v].x_addr);
         check($sformatf("vec%0d_count", v), int'(cnt_a),  vecs[v].x_cnt);
         check($sformatf("vec%0d_full", v),  int'(full_a), int'(vecs[v].x_full));
         check($sformatf("vec%0d_ovf", v),   int'(ovf_a),  int'(vecs[v].x_ovf));
      end

      // Fill: 17 distinct faults into the 16-deep table, 129 into the 200-deep one.
      step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      for (int i = 0; i < 129; i++) begin
         fill_tag[i] = {6'($urandom), 10'(i)};
         step(1'b0, 1'b1, fill_tag[i], 1'b0, 16'h0);
         if (i == 15) check("full_after_16", int'(full_a), 1);
         if (i == 16) check("ovf_after_17", int'(ovf_a), 1);
      end
      step(1'b0, 1'b0, 16'h0, 1'b1, fill_tag[15]);
      check("slot15_addr16", int'(addr_a), 15);
      step(1'b0, 1'b0, 16'h0, 1'b1, fill_tag[128]);
      check("slot128_sel200", int'(sel_b), 1);
      check("slot128_addr200", int'(addr_b), 0);
      check("slot128_miss16", int'(hit_a), 0);

      // CLR with FAIL_VALID and a lookup: lookup uses the pre-clear table, fault dropped.
      step(1'b1, 1'b1, 16'hABCD, 1'b1, fill_tag[3]);
      check("clr_prehit", int'(hit_b), 1);
      check("clr_count", int'(cnt_b), 0);
      check("clr_ovf16", int'(ovf_a), 0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h2000 + 16'(i), 1'b0, 16'h0);
      step(1'b1, 1'b1, 16'h3333, 1'b1, 16'h2001);
      check("clr4_prehit_addr", int'(addr_a), 1);
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h3333);
      check("clr4_new_miss", int'(hit_a), 0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h2001);
      check("clr4_old_miss", int'(hit_a), 0);

      // Randomized traffic over a small address space so duplicates and overflow occur.
      for (int n = 0; n < 400; n++) begin
         tag = {6'($urandom_range(0, 3)), 10'($urandom_range(0, 15))};
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), tag,
              ($urandom_range(0, 1) == 1),
              {6'($urandom_range(0, 3)), 10'($urandom_range(0, 15))});
      end

      // Reset in the middle of an insert burst, then the first insert lands in slot 0.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h4400 + 16'(i), 1'b1, 16'h4400);
      FAIL_VALID = 1'b1;
      async_reset();
      step(1'b0, 1'b1, 16'h5555, 1'b0, 16'h0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h5555);
      check("post_reset_slot0_hit", int'(hit_a), 1);
      check("post_reset_slot0_addr", int'(addr_b), 0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h4400);
      check("post_reset_old_miss", int'(hit_b), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
